// File: rtl/plic_bus_arbiter.sv
// Round-robin arbiter sharing the interrupt controller's register port between
// the CPU data port (master 0) and the debug port (master 1), with a slave timeout.
module plic_bus_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERROR_DATA = 32'hFFFF_FFFF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_m0_request,
  input  logic        i_m0_rw,
  input  logic [23:0] i_m0_address,
  input  logic [31:0] i_m0_wdata,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_ready,
  output logic        o_m0_error,
  input  logic        i_m1_request,
  input  logic        i_m1_rw,
  input  logic [23:0] i_m1_address,
  input  logic [31:0] i_m1_wdata,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_ready,
  output logic        o_m1_error,
  output logic        o_s_request,
  output logic        o_s_rw,
  output logic [23:0] o_s_address,
  output logic [31:0] o_s_wdata,
  input  logic [31:0] i_s_rdata,
  input  logic        i_s_ready,
  output logic        o_grant,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RECOVER} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              s_req_q, s_req_d;
  logic              s_rw_q, s_rw_d;
  logic [23:0]       s_addr_q, s_addr_d;
  logic [31:0]       s_wdata_q, s_wdata_d;
  logic              grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [1:0]        ready_q, ready_d;
  logic [1:0]        error_q, error_d;
  logic [1:0][31:0]  rdata_q, rdata_d;

  logic [1:0]        m_rw;
  logic [1:0][23:0]  m_addr;
  logic [1:0][31:0]  m_wdata;
  logic [1:0]        eligible;
  logic              pick;

  assign m_rw    = {i_m1_rw, i_m0_rw};
  assign m_addr  = {i_m1_address, i_m0_address};
  assign m_wdata = {i_m1_wdata, i_m0_wdata};
  // A master still seeing its completion pulse has not yet dropped its request.
  assign eligible = {i_m1_request & ~ready_q[1], i_m0_request & ~ready_q[0]};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    s_req_d      = s_req_q;
    s_rw_d       = s_rw_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    grant_d      = grant_q;
    ready_d      = '0;
    error_d      = '0;
    rdata_d      = rdata_q;
    pick         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          pick         = (&eligible) ? ~last_grant_q : eligible[1];
          s_rw_d       = m_rw[pick];
          s_addr_d     = m_addr[pick];
          s_wdata_d    = m_wdata[pick];
          s_req_d      = 1'b1;
          cnt_d        = '0;
          grant_d      = pick;
          last_grant_d = pick;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (s_req_q) cnt_d = cnt_q + 16'd1;
        // A slave answer on the final allowed cycle still counts as a normal completion.
        if (i_s_ready) begin
          rdata_d[grant_q] = i_s_rdata;
          ready_d[grant_q] = 1'b1;
          s_req_d          = 1'b0;
          state_d          = S_RECOVER;
        end else if (cnt_q == TO_LAST) begin
          rdata_d[grant_q] = ERROR_DATA;
          ready_d[grant_q] = 1'b1;
          error_d[grant_q] = 1'b1;
          s_req_d          = 1'b0;
          state_d          = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (!i_s_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      s_req_q      <= 1'b0;
      s_rw_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= '0;
      error_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      s_req_q      <= s_req_d;
      s_rw_q       <= s_rw_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_m0_rdata  = rdata_q[0];
  assign o_m1_rdata  = rdata_q[1];
  assign o_m0_ready  = ready_q[0];
  assign o_m1_ready  = ready_q[1];
  assign o_m0_error  = error_q[0];
  assign o_m1_error  = error_q[1];
  assign o_s_request = s_req_q;
  assign o_s_rw      = s_rw_q;
  assign o_s_address = s_addr_q;
  assign o_s_wdata   = s_wdata_q;
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_plic_bus_arbiter.sv
// Scoreboard bench for plic_bus_arbiter: two master drivers, a slave whose
// answer latency is encoded in the address, and a monitor checking both sides.
module tb_plic_bus_arbiter;

  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       m_req, m_rw, m_rdy, m_err;
  logic [1:0][23:0] m_addr;
  logic [1:0][31:0] m_wd, m_rdata;
  logic             s_req, s_rw, s_ready, grant, busy;
  logic [23:0]      s_addr;
  logic [31:0]      s_wdata, s_rdata;
  int               cyc = 0;
  int               n_chk = 0, n_fail = 0;

  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {logic rw; logic [23:0] addr; logic [31:0] wdata; int hi;} req_t;
  rsp_t exp_q[2][$];
  req_t iss_q[2][$];
  int   grant_log[$];

  plic_bus_arbiter #(.TIMEOUT(TO), .ERROR_DATA(32'hFFFF_FFFF)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_m0_request(m_req[0]), .i_m0_rw(m_rw[0]), .i_m0_address(m_addr[0]), .i_m0_wdata(m_wd[0]),
    .o_m0_rdata(m_rdata[0]), .o_m0_ready(m_rdy[0]), .o_m0_error(m_err[0]),
    .i_m1_request(m_req[1]), .i_m1_rw(m_rw[1]), .i_m1_address(m_addr[1]), .i_m1_wdata(m_wd[1]),
    .o_m1_rdata(m_rdata[1]), .o_m1_ready(m_rdy[1]), .o_m1_error(m_err[1]),
    .o_s_request(s_req), .o_s_rw(s_rw), .o_s_address(s_addr), .o_s_wdata(s_wdata),
    .i_s_rdata(s_rdata), .i_s_ready(s_ready), .o_grant(grant), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave answer latency (cycles after it first sees request); 0 = never answers.
  function automatic int lat_of(input logic [23:0] a);
    return int'(a[3:0] ^ 4'h5);
  endfunction
  function automatic logic [31:0] sdata(input logic [23:0] a);
    return {8'h00, a ^ 24'h200006};
  endfunction

  int scnt;
  always @(posedge clk) begin
    if (rst || !s_req) begin
      scnt    <= 0;
      s_ready <= 1'b0;
    end else begin
      scnt    <= scnt + 1;
      s_ready <= (lat_of(s_addr) != 0) && (scnt + 1 >= lat_of(s_addr));
    end
  end
  assign s_rdata = sdata(s_addr);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: the slave completes iff it answers before the allowed window closes.
  task automatic do_access(input int m, input logic rw, input logic [23:0] a,
                           input logic [31:0] wd, output int dt);
    int   l;
    logic ok;
    int   t0;
    rsp_t r;
    req_t q;
    l  = lat_of(a);
    ok = (l >= 1) && (l <= TO - 1);
    r.rdata = ok ? sdata(a) : 32'hFFFF_FFFF;
    r.err   = !ok;
    q.rw = rw; q.addr = a; q.wdata = wd; q.hi = ok ? l + 1 : TO;
    exp_q[m].push_back(r);
    iss_q[m].push_back(q);
    m_rw[m] = rw; m_addr[m] = a; m_wd[m] = wd; m_req[m] = 1'b1;
    t0 = cyc;
    dt = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_rdy[m]) begin
        dt = cyc - t0;
        break;
      end
      if (s_req && grant == m[0]) begin
        m_addr[m] = 24'($urandom);
        m_wd[m]   = $urandom;
      end
    end
    m_req[m] = 1'b0;
    if (dt < 0) check("ready_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_wait_expired", 32'd1, 32'd0);
  endtask

  // Monitor: master completions and slave-side forwarding.
  initial begin
    logic prev;
    int   hi_cnt;
    req_t cur;
    rsp_t r;
    prev = 1'b0;
    hi_cnt = 0;
    cur = '{rw: 1'b0, addr: '0, wdata: '0, hi: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (m_rdy[m]) begin
            if (exp_q[m].size() == 0) check($sformatf("spurious_ready_m%0d", m), 32'd1, 32'd0);
            else begin
              r = exp_q[m].pop_front();
              check($sformatf("rdata_m%0d", m), m_rdata[m], r.rdata);
              check($sformatf("error_m%0d", m), 32'(m_err[m]), 32'(r.err));
              check($sformatf("grant_at_ready_m%0d", m), 32'(grant), 32'(m));
            end
          end else if (m_err[m]) check($sformatf("error_without_ready_m%0d", m), 32'd1, 32'd0);
        end
        if (s_req && !prev) begin
          if (iss_q[grant].size() == 0) check("unrequested_grant", 32'd1, 32'd0);
          else begin
            cur = iss_q[grant].pop_front();
            grant_log.push_back(int'(grant));
            check("s_rw", 32'(s_rw), 32'(cur.rw));
            check("s_address", 32'(s_addr), 32'(cur.addr));
            if (cur.rw) check("s_wdata", s_wdata, cur.wdata);
          end
          hi_cnt = 1;
        end else if (s_req && prev) begin
          hi_cnt++;
          check("s_address_stable", 32'(s_addr), 32'(cur.addr));
          if (cur.rw) check("s_wdata_stable", s_wdata, cur.wdata);
        end else if (!s_req && prev) begin
          check("s_request_cycles", 32'(hi_cnt), 32'(cur.hi));
        end
        prev = s_req;
      end
    end
  end

  initial begin
    int dt, d1;
    req_t q;
    rst = 1'b1; m_req = '0; m_rw = '0; m_addr = '0; m_wd = '0;
    repeat (3) @(negedge clk);
    check("rst_s_request", 32'(s_req), 32'd0);
    check("rst_s_rw", 32'(s_rw), 32'd0);
    check("rst_s_address", 32'(s_addr), 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_ready", 32'(m_rdy), 32'd0);
    check("rst_error", 32'(m_err), 32'd0);
    check("rst_rdata0", m_rdata[0], 32'd0);
    check("rst_rdata1", m_rdata[1], 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Simultaneous requests from reset, then a repeated tie.
    for (int k = 0; k < 2; k++) begin
      grant_log.delete();
      fork
        do_access(0, 1'b0, 24'h000104, 32'd0, dt);
        do_access(1, 1'b0, 24'h000207, 32'd0, d1);
      join
      wait_idle();
      check("tie_count", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
        check("tie_first", 32'(grant_log[0]), 32'd0);
        check("tie_second", 32'(grant_log[1]), 32'd1);
      end
    end

    // Single read with a one-cycle slave.
    @(negedge clk);
    do_access(0, 1'b0, 24'h200004, 32'd0, dt);
    check("read_latency", 32'(dt), 32'd3);
    check("read_rdata", m_rdata[0], 32'd2);
    @(negedge clk);
    check("busy_n4", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_n5", 32'(busy), 32'd0);

    do_access(1, 1'b1, 24'h002000, 32'h0000_001E, dt);
    wait_idle();

    // Slave never answers, then a normal access.
    do_access(0, 1'b0, 24'h000035, 32'd0, dt);
    check("timeout_latency", 32'(dt), 32'(TO + 1));
    wait_idle();
    do_access(0, 1'b0, 24'h000110, 32'd0, dt);
    check("after_timeout_latency", 32'(dt), 32'd7);
    wait_idle();
    // Answer on the last allowed cycle, then one cycle too late.
    do_access(0, 1'b0, 24'h000042, 32'd0, dt);
    check("edge_latency", 32'(dt), 32'(TO + 1));
    wait_idle();
    do_access(1, 1'b0, 24'h00004D, 32'd0, dt);
    check("late_latency", 32'(dt), 32'(TO + 1));
    wait_idle();

    // Reset in the middle of an access.
    q = '{rw: 1'b0, addr: 24'h000305, wdata: 32'd0, hi: TO};
    iss_q[0].push_back(q);
    m_rw[0] = 1'b0; m_addr[0] = 24'h000305; m_req[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_s_request", 32'(s_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_s_request", 32'(s_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(m_rdy), 32'd0);
    m_req[0] = 1'b0;
    iss_q[0].delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    do_access(0, 1'b0, 24'h000404, 32'd0, dt);
    check("post_reset_latency", 32'(dt), 32'd3);
    wait_idle();

    // Random traffic from both masters.
    fork
      for (int k = 0; k < 40; k++) begin
        int d;
        repeat ($urandom_range(0, 6)) @(negedge clk);
        do_access(0, 1'($urandom), 24'($urandom), $urandom, d);
      end
      for (int k = 0; k < 40; k++) begin
        int d;
        repeat ($urandom_range(0, 6)) @(negedge clk);
        do_access(1, 1'($urandom), 24'($urandom), $urandom, d);
      end
    join
    wait_idle();
    repeat (3) @(negedge clk);
    check("exp_q0_empty", 32'(exp_q[0].size()), 32'd0);
    check("exp_q1_empty", 32'(exp_q[1].size()), 32'd0);
    check("iss_q0_empty", 32'(iss_q[0].size()), 32'd0);
    check("iss_q1_empty", 32'(iss_q[1].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
